// File: rtl/conv_block_sequencer.sv
// rtl/conv_block_sequencer.sv - frame sequencer driving the address FSM through clear/load/process per block.
// Optional watchdog on LOAD/PROC compiled in with SEQ_WATCHDOG_EN.
module conv_block_sequencer #(
  parameter int NB_BLOCK   = 8,
  parameter int NB_TIMEOUT = 16
) (
  input  logic                i_CLK,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [NB_BLOCK-1:0] i_numBlocks,
  input  logic                i_changeBlock,
  input  logic                i_EoP,
  output logic                o_fsmReset,
  output logic                o_SoP,
  output logic                o_bank,
  output logic [NB_BLOCK-1:0] o_blockIdx,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_PROC  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  if (NB_BLOCK < 1 || NB_TIMEOUT < 2) begin : g_param_check
    $error("conv_block_sequencer: NB_BLOCK must be >= 1 and NB_TIMEOUT >= 2");
  end

  logic [2:0]          state_q, state_d;
  logic                ret_idle_q, ret_idle_d;
  logic [NB_BLOCK-1:0] num_q, num_d;
  logic [NB_BLOCK-1:0] idx_q, idx_d;
  logic                bank_q, bank_d;
  logic                error_q, error_d;
  logic                fsm_reset_q, fsm_reset_d;
  logic                sop_q, sop_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                timeout;

`ifdef SEQ_WATCHDOG_EN
  logic [NB_TIMEOUT-1:0] wd_q, wd_d;

  assign timeout = ((state_q == S_LOAD) || (state_q == S_PROC)) && (&wd_q);

  // Restart the count on every state change so each wait gets a full budget.
  always_comb begin
    wd_d = wd_q;
    if (state_d != state_q) begin
      wd_d = '0;
    end else if ((state_q == S_LOAD) || (state_q == S_PROC)) begin
      wd_d = wd_q + NB_TIMEOUT'(1);
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ret_idle_d = ret_idle_q;
    num_d      = num_q;
    idx_d      = idx_q;
    bank_d     = bank_q;
    error_d    = error_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          error_d = 1'b0;
          if (i_numBlocks == '0) begin
            state_d = S_DONE;
          end else begin
            num_d      = i_numBlocks;
            idx_d      = '0;
            bank_d     = 1'b0;
            ret_idle_d = 1'b0;
            state_d    = S_CLEAR;
          end
        end
      end
      S_CLEAR: state_d = ret_idle_q ? S_IDLE : S_LOAD;
      S_LOAD:  if (i_changeBlock) state_d = S_START;
      S_START: state_d = S_PROC;
      S_PROC: begin
        if (i_EoP) begin
          if (idx_q == num_q - NB_BLOCK'(1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + NB_BLOCK'(1);
            bank_d  = ~bank_q;
            state_d = S_CLEAR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort/timeout outrank EoP, so any index/bank advance above is undone.
    if ((state_q != S_IDLE) && (i_abort || timeout)) begin
      error_d    = 1'b1;
      ret_idle_d = 1'b1;
      idx_d      = idx_q;
      bank_d     = bank_q;
      state_d    = S_CLEAR;
    end

    fsm_reset_d = (state_d == S_CLEAR);
    sop_d       = (state_d == S_START);
    done_d      = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      ret_idle_q  <= 1'b0;
      num_q       <= '0;
      idx_q       <= '0;
      bank_q      <= 1'b0;
      error_q     <= 1'b0;
      fsm_reset_q <= 1'b0;
      sop_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_idle_q  <= ret_idle_d;
      num_q       <= num_d;
      idx_q       <= idx_d;
      bank_q      <= bank_d;
      error_q     <= error_d;
      fsm_reset_q <= fsm_reset_d;
      sop_q       <= sop_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_fsmReset = fsm_reset_q;
  assign o_SoP      = sop_q;
  assign o_bank     = bank_q;
  assign o_blockIdx = idx_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_error    = error_q;

endmodule

// File: tb/tb_conv_block_sequencer.sv
// tb/tb_conv_block_sequencer.sv - directed self-checking bench for conv_block_sequencer.
module tb_conv_block_sequencer;

  logic       i_CLK = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_start = 1'b0;
  logic       i_abort = 1'b0;
  logic [7:0] i_numBlocks = 8'd0;
  logic       i_changeBlock = 1'b0;
  logic       i_EoP = 1'b0;
  logic       o_fsmReset, o_SoP, o_bank, o_busy, o_done, o_error;
  logic [7:0] o_blockIdx;

  int checks = 0;
  int errors = 0;

  always #5 i_CLK = ~i_CLK;

  conv_block_sequencer #(
    .NB_BLOCK   (8),
`ifdef SEQ_WATCHDOG_EN
    .NB_TIMEOUT (4)
`else
    .NB_TIMEOUT (16)
`endif
  ) dut (
    .i_CLK         (i_CLK),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_numBlocks   (i_numBlocks),
    .i_changeBlock (i_changeBlock),
    .i_EoP         (i_EoP),
    .o_fsmReset    (o_fsmReset),
    .o_SoP         (o_SoP),
    .o_bank        (o_bank),
    .o_blockIdx    (o_blockIdx),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error)
  );

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge i_CLK);
    #1;
  endtask

  // Packed compare: {fsmReset, SoP, bank, busy, done, error, blockIdx}
  task automatic expect_out(input string tag, input logic fr, input logic sop, input logic bank,
                            input logic [7:0] idx, input logic busy, input logic done, input logic err);
    logic [13:0] obs;
    logic [13:0] exp;
    obs = {o_fsmReset, o_SoP, o_bank, o_busy, o_done, o_error, o_blockIdx};
    exp = {fr, sop, bank, busy, done, err, idx};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed fr/sop/bank/busy/done/err/idx=%b/%b/%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%b/%b/%0d",
             tag, obs[13], obs[12], obs[11], obs[10], obs[9], obs[8], obs[7:0],
             exp[13], exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  initial begin
    // Reset and idle: address-FSM pulses must not wake the sequencer.
    tick();
    tick();
    i_reset = 1'b0;
    expect_out("reset", 0, 0, 0, 8'd0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      i_changeBlock = i[0];
      i_EoP         = ~i[0];
      tick();
      expect_out($sformatf("idle_%0d", i), 0, 0, 0, 8'd0, 0, 0, 0);
    end
    i_changeBlock = 1'b0;
    i_EoP         = 1'b0;

    // N=3 normal frame.
    i_start     = 1'b1;
    i_numBlocks = 8'd3;
    tick();
    i_start = 1'b0;
    expect_out("n3_clear0", 1, 0, 0, 8'd0, 1, 0, 0);
    for (int b = 0; b < 3; b++) begin
      tick();
      expect_out($sformatf("n3_load%0d", b), 0, 0, b[0], 8'(b), 1, 0, 0);
      i_EoP = 1'b1;
      tick();
      i_EoP = 1'b0;
      expect_out($sformatf("n3_load_eop_ign%0d", b), 0, 0, b[0], 8'(b), 1, 0, 0);
      i_changeBlock = 1'b1;
      tick();
      i_changeBlock = 1'b0;
      expect_out($sformatf("n3_sop%0d", b), 0, 1, b[0], 8'(b), 1, 0, 0);
      tick();
      expect_out($sformatf("n3_proc%0d", b), 0, 0, b[0], 8'(b), 1, 0, 0);
      i_EoP = 1'b1;
      tick();
      i_EoP = 1'b0;
      if (b < 2)
        expect_out($sformatf("n3_clear%0d", b + 1), 1, 0, ~b[0], 8'(b + 1), 1, 0, 0);
      else
        expect_out("n3_done", 0, 0, 0, 8'd2, 1, 1, 0);
    end
    tick();
    expect_out("n3_idle", 0, 0, 0, 8'd2, 0, 0, 0);

    // Empty frame: done next cycle, indices hold.
    i_start     = 1'b1;
    i_numBlocks = 8'd0;
    tick();
    i_start = 1'b0;
    expect_out("n0_done", 0, 0, 0, 8'd2, 1, 1, 0);
    tick();
    expect_out("n0_idle", 0, 0, 0, 8'd2, 0, 0, 0);

    // N=4, abort in PROC of block 1.
    i_start     = 1'b1;
    i_numBlocks = 8'd4;
    tick();
    i_start = 1'b0;
    expect_out("n4_clear0", 1, 0, 0, 8'd0, 1, 0, 0);
    tick();
    i_changeBlock = 1'b1;
    tick();
    i_changeBlock = 1'b0;
    tick();
    expect_out("n4_proc0", 0, 0, 0, 8'd0, 1, 0, 0);
    i_EoP = 1'b1;
    tick();
    i_EoP = 1'b0;
    expect_out("n4_clear1", 1, 0, 1, 8'd1, 1, 0, 0);
    tick();
    i_changeBlock = 1'b1;
    tick();
    i_changeBlock = 1'b0;
    tick();
    expect_out("n4_proc1", 0, 0, 1, 8'd1, 1, 0, 0);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    expect_out("n4_abort_clear", 1, 0, 1, 8'd1, 1, 0, 1);
    tick();
    expect_out("n4_abort_idle", 0, 0, 1, 8'd1, 0, 0, 1);
    tick();
    expect_out("n4_abort_idle2", 0, 0, 1, 8'd1, 0, 0, 1);

    // N=2: new start clears error; start while busy ignored; abort beats EoP.
    i_start     = 1'b1;
    i_numBlocks = 8'd2;
    tick();
    i_start = 1'b0;
    expect_out("n2_clear0_errclr", 1, 0, 0, 8'd0, 1, 0, 0);
    i_start     = 1'b1;
    i_numBlocks = 8'd1;
    tick();
    i_start = 1'b0;
    expect_out("n2_load0_start_ign", 0, 0, 0, 8'd0, 1, 0, 0);
    i_changeBlock = 1'b1;
    tick();
    i_changeBlock = 1'b0;
    tick();
    i_EoP = 1'b1;
    tick();
    i_EoP = 1'b0;
    expect_out("n2_clear1_not_done", 1, 0, 1, 8'd1, 1, 0, 0);
    tick();
    i_changeBlock = 1'b1;
    tick();
    i_changeBlock = 1'b0;
    tick();
    expect_out("n2_proc1", 0, 0, 1, 8'd1, 1, 0, 0);
    i_abort     = 1'b1;
    i_EoP       = 1'b1;
    i_start     = 1'b1;
    i_numBlocks = 8'd5;
    tick();
    i_abort = 1'b0;
    i_EoP   = 1'b0;
    i_start = 1'b0;
    expect_out("abort_eop_clear", 1, 0, 1, 8'd1, 1, 0, 1);
    tick();
    expect_out("abort_eop_idle", 0, 0, 1, 8'd1, 0, 0, 1);

    // Stall in LOAD with no changeBlock.
    i_start     = 1'b1;
    i_numBlocks = 8'd1;
    tick();
    i_start = 1'b0;
    tick();
    expect_out("stall_load", 0, 0, 0, 8'd0, 1, 0, 0);
`ifdef SEQ_WATCHDOG_EN
    repeat (15) tick();
    expect_out("wd_load_last", 0, 0, 0, 8'd0, 1, 0, 0);
    tick();
    expect_out("wd_clear", 1, 0, 0, 8'd0, 1, 0, 1);
    tick();
    expect_out("wd_idle", 0, 0, 0, 8'd0, 0, 0, 1);
`else
    repeat (1000) tick();
    expect_out("stall_load_1000", 0, 0, 0, 8'd0, 1, 0, 0);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    expect_out("stall_abort_clear", 1, 0, 0, 8'd0, 1, 0, 1);
    tick();
    expect_out("stall_abort_idle", 0, 0, 0, 8'd0, 0, 0, 1);
`endif

    // Reset mid-frame: straight to IDLE with no clear pulse.
    i_start     = 1'b1;
    i_numBlocks = 8'd2;
    tick();
    i_start = 1'b0;
    tick();
    i_changeBlock = 1'b1;
    tick();
    i_changeBlock = 1'b0;
    tick();
    i_EoP = 1'b1;
    tick();
    i_EoP = 1'b0;
    expect_out("mid_clear1", 1, 0, 1, 8'd1, 1, 0, 0);
    tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    expect_out("mid_reset", 0, 0, 0, 8'd0, 0, 0, 0);
    tick();
    expect_out("mid_reset_idle", 0, 0, 0, 8'd0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
